// File: rtl/ring_token_arbiter.sv
// Token-ring arbiter: N requesters share one output stage; a rotating token sets priority,
// grants end on last, request drop or a MAX_HOLD cycle limit, and each grant is followed by a one-cycle gap.
module ring_token_arbiter #(
    parameter int N        = 3,
    parameter int W        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
    input  logic [N*W-1:0]   data_in,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             timeout
);

    localparam int          IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU   = N;
    localparam logic [7:0]  MAXH = 8'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   tok, tok_n;
    logic [IW-1:0]   holder, holder_n;
    logic [IW-1:0]   pick;
    logic            found;
    logic [N-1:0]    gnt_n;
    logic [7:0]      cnt, cnt_n;
    logic            timeout_n;
    logic            hreq, hlast;
    logic            rel_a, rel_b, rel_c;

    // Round-robin scan starting at the token holder position.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = (32'(tok) + i) % NU;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign hreq  = req[holder];
    assign hlast = last[holder];
    assign rel_a = hreq & hlast;
    assign rel_b = ~hreq;
    assign rel_c = (cnt == MAXH);

    always_comb begin
        state_n   = state;
        tok_n     = tok;
        holder_n  = holder;
        gnt_n     = gnt;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    state_n  = GRANT;
                    holder_n = pick;
                    gnt_n    = N'(1) << pick;
                    cnt_n    = 8'd1;
                end
            end
            GRANT: begin
                cnt_n = rel_c ? cnt : cnt + 8'd1;
                if (rel_a || rel_b || rel_c) begin
                    state_n   = GAP;
                    gnt_n     = '0;
                    tok_n     = (32'(holder) == NU - 1) ? '0 : holder + 1'b1;
                    // Only a pure hold-limit release counts as a timeout.
                    timeout_n = rel_c & ~rel_a & ~rel_b;
                end
            end
            GAP: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tok     <= '0;
            holder  <= '0;
            gnt     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            tok     <= tok_n;
            holder  <= holder_n;
            gnt     <= gnt_n;
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end

    assign busy      = (state == GRANT);
    assign out_valid = busy & hreq;
    assign out_data  = busy ? data_in[32'(holder) * W +: W] : '0;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Directed bench for ring_token_arbiter (N=3, W=4, MAX_HOLD=8) with hand-computed expectations.
module tb_ring_token_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  last;
    logic [11:0] data_in;
    logic [2:0]  gnt;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    ring_token_arbiter #(.N(3), .W(4), .MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .data_in  (data_in),
        .gnt      (gnt),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 3'b000;
        last = 3'b000;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        req     = 3'b111;
        last    = 3'b000;
        tick();
        tick();
        #1;
        tests_run++;
        if (gnt !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        tests_run++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_timeout: got %b%b want 00", busy, timeout); end
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'h0) begin tests_failed++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
        // First arbitration after reset favours requester 0.
        rst = 1'b0;
        tick();
        tests_run++;
        if (gnt !== 3'b001) begin tests_failed++; $display("FAIL reset_first_prio: got %b want 001", gnt); end
    endtask

    task automatic test_last_release();
        do_reset();
        req = 3'b110;
        #1;
        tests_run++;
        if (gnt !== 3'b000) begin tests_failed++; $display("FAIL last_pre_gnt: got %b want 000", gnt); end
        tick();
        tests_run++;
        if (gnt !== 3'b010 || busy !== 1'b1) begin tests_failed++; $display("FAIL last_gnt1: got %b busy=%b want 010 busy=1", gnt, busy); end
        tests_run++;
        if (out_data !== 4'hB || out_valid !== 1'b1) begin tests_failed++; $display("FAIL last_out: got d=%h v=%b want d=b v=1", out_data, out_valid); end
        tick();
        tick();
        last = 3'b010;
        #1;
        tests_run++;
        if (gnt !== 3'b010) begin tests_failed++; $display("FAIL last_gnt3: got %b want 010", gnt); end
        tick();
        last = 3'b000;
        #1;
        tests_run++;
        if (gnt !== 3'b000 || timeout !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL last_gap: got gnt=%b to=%b busy=%b want 000 0 0", gnt, timeout, busy); end
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'h0) begin tests_failed++; $display("FAIL last_gap_out: got v=%b d=%h want 0 0", out_valid, out_data); end
        tick();
        tests_run++;
        if (gnt !== 3'b000) begin tests_failed++; $display("FAIL last_idle: got %b want 000", gnt); end
        tick();
        tests_run++;
        if (gnt !== 3'b100 || out_data !== 4'hC) begin tests_failed++; $display("FAIL last_next: got gnt=%b d=%h want 100 c", gnt, out_data); end
    endtask

    task automatic test_timeout_rotation();
        int order [4] = '{0, 1, 2, 0};
        logic [3:0] exp_d;
        logic [2:0] exp_g;
        do_reset();
        req = 3'b111;
        tick();
        for (int g = 0; g < 4; g++) begin
            exp_g = 3'b001 << order[g];
            exp_d = data_in[order[g] * 4 +: 4];
            for (int k = 1; k <= 8; k++) begin
                tests_run++;
                if (gnt !== exp_g || out_data !== exp_d || timeout !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rot_grant g%0d c%0d: got gnt=%b d=%h to=%b want %b %h 0", g, k, gnt, out_data, timeout, exp_g, exp_d);
                end
                tick();
            end
            tests_run++;
            if (gnt !== 3'b000 || timeout !== 1'b1) begin tests_failed++; $display("FAIL rot_gap g%0d: got gnt=%b to=%b want 000 1", g, gnt, timeout); end
            tick();
            tests_run++;
            if (timeout !== 1'b0 || gnt !== 3'b000) begin tests_failed++; $display("FAIL rot_idle g%0d: got gnt=%b to=%b want 000 0", g, gnt, timeout); end
            tick();
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 3'b100;
        tick();
        tests_run++;
        if (gnt !== 3'b100) begin tests_failed++; $display("FAIL drop_gnt: got %b want 100", gnt); end
        tick();
        req = 3'b000;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || gnt !== 3'b100) begin tests_failed++; $display("FAIL drop_valid: got v=%b gnt=%b want 0 100", out_valid, gnt); end
        tick();
        tests_run++;
        if (gnt !== 3'b000 || timeout !== 1'b0) begin tests_failed++; $display("FAIL drop_release: got gnt=%b to=%b want 000 0", gnt, timeout); end
        tick();
        req = 3'b111;
        tick();
        tests_run++;
        if (gnt !== 3'b001) begin tests_failed++; $display("FAIL drop_tok_wrap: got %b want 001", gnt); end
    endtask

    task automatic test_last_at_max();
        do_reset();
        req = 3'b001;
        tick();
        tick();
        tick();
        // last on non-holders is ignored.
        last = 3'b110;
        tick();
        last = 3'b000;
        #1;
        tests_run++;
        if (gnt !== 3'b001) begin tests_failed++; $display("FAIL max_foreign_last: got %b want 001", gnt); end
        for (int k = 0; k < 4; k++) tick();
        last = 3'b001;
        #1;
        tests_run++;
        if (gnt !== 3'b001) begin tests_failed++; $display("FAIL max_cycle8: got %b want 001", gnt); end
        tick();
        last = 3'b000;
        #1;
        tests_run++;
        if (gnt !== 3'b000 || timeout !== 1'b0) begin tests_failed++; $display("FAIL max_last_coincide: got gnt=%b to=%b want 000 0", gnt, timeout); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 3'b100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if (gnt !== 3'b000 || busy !== 1'b0 || out_valid !== 1'b0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_out: got gnt=%b busy=%b v=%b to=%b want 000 0 0 0", gnt, busy, out_valid, timeout);
        end
        rst = 1'b0;
        req = 3'b101;
        tick();
        tests_run++;
        if (gnt !== 3'b001) begin tests_failed++; $display("FAIL rstmid_regrant: got %b want 001", gnt); end
    endtask

    task automatic test_single_requester();
        logic exp;
        do_reset();
        req = 3'b010;
        for (int c = 0; c < 16; c++) begin
            last = (c % 2 == 0) ? 3'b010 : 3'b000;
            #1;
            exp = (c % 4 == 1) || (c % 4 == 2);
            tests_run++;
            if (gnt[1] !== exp) begin tests_failed++; $display("FAIL single_pattern c%0d: got %b want %b", c, gnt[1], exp); end
            tick();
        end
    endtask

    initial begin
        data_in = {4'hC, 4'hB, 4'hA};
        rst     = 1'b1;
        req     = 3'b000;
        last    = 3'b000;
        test_reset();
        test_last_release();
        test_timeout_rotation();
        test_req_drop();
        test_last_at_max();
        test_reset_mid_grant();
        test_single_requester();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ring_token_arbiter.md
RING_TOKEN_ARBITER -- requirements
Module: ring_token_arbiter

Interface
REQ-001 SHALL have parameter N, default 3, giving the number of requesters sharing the ring output stage.
REQ-002 SHALL have parameter W, default 4, giving the data width per requester.
REQ-003 SHALL have parameter MAX_HOLD, default 8, giving the maximum grant length in cycles (legal range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, N bits: request, one bit per requester.
REQ-007 SHALL have port last, input, N bits: end-of-burst marker, one bit per requester.
REQ-008 SHALL have port data_in, input, N*W bits: requester i data occupies bits [i*W +: W].
REQ-009 SHALL have port gnt, output, N bits: one-hot or zero grant, registered.
REQ-010 SHALL have port out_data, output, W bits: data of the granted requester.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data carries a valid beat.
REQ-012 SHALL have port busy, output, 1 bit: high while in state GRANT.
REQ-013 SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-015 SHALL keep token pointer tok (0..N-1) naming the highest-priority requester.
REQ-016 In IDLE with req!=0, SHALL select the first asserted req scanning tok, tok+1, ... mod N; set gnt to that one-hot; load hold counter with 1; go to GRANT next cycle.
REQ-017 In IDLE with req==0, SHALL stay in IDLE with gnt=0.
REQ-018 Grant latency SHALL be exactly 1 cycle from req sampled in IDLE to gnt high.
REQ-019 In GRANT, out_data SHALL equal data_in slice of the holder (combinational mux) and out_valid SHALL equal req[holder].
REQ-020 When gnt=0, out_data SHALL be 0 and out_valid SHALL be 0.
REQ-021 In GRANT, the hold counter SHALL increment every cycle, saturating at MAX_HOLD.
REQ-022 Release SHALL occur at the end of a GRANT cycle when any of the following holds: (a) req[holder]=1 and last[holder]=1; (b) req[holder]=0; (c) hold counter == MAX_HOLD.
REQ-023 On release, SHALL clear gnt, set tok to (holder+1) mod N, and enter GAP.
REQ-024 timeout SHALL pulse high for exactly one cycle (the GAP cycle) only when release is by (c) alone, i.e. (a) and (b) both false.
REQ-025 GAP SHALL last exactly one cycle with gnt=0, then go to IDLE; requests are not sampled in GAP.
REQ-026 The minimum turnaround between grants SHALL be 2 idle cycles (GAP, then IDLE arbitration).
REQ-027 If (a) and (c) coincide, the release SHALL be treated as normal (timeout=0).
REQ-028 last on a non-holder, or last with req low, SHALL be ignored.
REQ-029 Changes to req of non-holders during GRANT SHALL not affect the current grant.
REQ-030 tok wrap-around SHALL be N-1 -> 0.
REQ-031 With a single persistent requester, it SHALL be re-granted after each GAP regardless of tok.

Reset
REQ-032 While rst=1 at a clock edge, SHALL force state=IDLE, tok=0, gnt=0, hold counter=0, timeout=0, busy=0.
REQ-033 Reset asserted mid-GRANT SHALL drop gnt on the next edge with no timeout pulse and no tok advance beyond 0.
REQ-034 First arbitration after reset release SHALL give priority to requester 0.

Verification
REQ-035 Reset then req=3'b110 held -> gnt=3'b010 one cycle later; holder 1 keeps req; last[1] pulsed on 3rd grant cycle -> gnt=0 next cycle, GAP, then gnt=3'b100.
REQ-036 req=3'b111 held, last always 0, N=3, MAX_HOLD=8 -> each grant lasts 8 cycles, timeout pulses after each, grant order 0,1,2,0; out_data tracks the holder's slice.
REQ-037 Holder 2 granted, req[2] drops mid-burst -> gnt=0 next edge, timeout=0, tok=0.
REQ-038 last[0]=1 on the cycle the counter reaches MAX_HOLD -> release with timeout=0.
REQ-039 rst asserted during GRANT of requester 2 -> gnt=0, busy=0, out_valid=0 next cycle; after release with req=3'b101 -> gnt=3'b001.
REQ-040 Only req[1] asserted forever with last[1] pulsed every 2 cycles -> gnt[1] pattern 2 high, 2 low repeating.
